axis_max_finder: RTL
====================

# axis_max_finder

Parametrised AXI-Stream packet max finder, the next generation of the maxtest block. It consumes TLAST-delimited packets on an AXI-Stream slave and reports one result per packet on a handshaked result port: the maximum value, the beat index of that maximum, the beat count and an overflow flag. It supports signed or unsigned compare, configurable widths and full backpressure. It sits directly behind the sample stream source, in the position maxtest3 occupies today.

## Interface
Parameters:
- DATA_WIDTH, 32: stream sample width.
- IDX_WIDTH, 16: width of the index and count fields.
- SIGNED, 0: 1 = two's-complement compare; 0 = unsigned compare.

Ports:
- s_axis_aclk  in  1  single clock; all logic is on its rising edge.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_WIDTH  sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tlast  in  1  last beat of the packet.
- s_axis_tready  out  1  block can accept a beat.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  result accepted.
- m_axis_max  out  DATA_WIDTH  packet maximum.
- m_axis_idx  out  IDX_WIDTH  beat index of the first occurrence of the maximum (0-based).
- m_axis_count  out  IDX_WIDTH  beats in the packet, saturating.
- m_axis_ovf  out  1  packet exceeded 2^IDX_WIDTH-1 beats.

## Operation
- A beat transfers when s_axis_tvalid and s_axis_tready are both high.
- States:
  - IDLE: no beat of the current packet has been taken yet.
  - ACCUM: at least one beat has been taken.
- First beat of a packet, taken in IDLE:
  - run_max = tdata; run_idx = 0; beat counter = 1; ovf = 0.
  - Go to ACCUM, unless tlast is also high.
- Each later beat:
  - If tdata > run_max (strictly greater, under the SIGNED rule): run_max = tdata and run_idx = current beat index.
  - On ties, the earlier index is kept.
- Beat counter and index:
  - Both saturate at 2^IDX_WIDTH-1.
  - Once saturated, ovf is set.
  - A new maximum seen after saturation reports idx = 2^IDX_WIDTH-1.
- Beat with tlast:
  - run_max, run_idx, count and ovf (including the effect of this beat) are copied to the result register.
  - m_axis_tvalid is set and the state returns to IDLE.
- Single-beat packet: max = tdata, idx = 0, count = 1.
- Result register is a single entry:
  - It holds until m_axis_tvalid and m_axis_tready are both high.
  - The m_axis_* outputs are stable while m_axis_tvalid is high and m_axis_tready is low.
- s_axis_tready = !(m_axis_tvalid && !m_axis_tready). This is a combinational path from m_axis_tready, and it is intentional.
- Simultaneous tlast beat and result acceptance in the same cycle: the old result is consumed, the new result is loaded, and m_axis_tvalid stays high.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - m_axis_tvalid = 0.
  - m_axis_max, m_axis_idx, m_axis_count and m_axis_ovf = 0.
  - Running registers = 0.
  - s_axis_tready = 1 in the first cycle after release.
- Latency: m_axis_tvalid rises on the clock edge that accepts the tlast beat, so the result is visible 1 cycle after that handshake.
- Throughput: 1 beat per cycle with m_axis_tready held high, including back-to-back single-beat packets.
- Reset mid-packet: the partial packet is discarded and no result is produced.
- Reset with a pending result: the result is dropped.
- s_axis_tvalid low inside a packet: the block holds its state indefinitely.

## Configuration
- AXIS_MAX_FINDER_MIN_TRACK_EN.
- When defined:
  - The block also tracks the packet minimum. Compare is strictly less-than, so the first occurrence wins on ties.
  - It adds output ports m_axis_min (DATA_WIDTH) and m_axis_min_idx (IDX_WIDTH).
  - Both new ports are registered and handshaked together with the max result, and reset to 0.
- When undefined: those ports and the associated logic are absent, and behaviour is otherwise identical.

## Test plan
- Unsigned packet of 5, 9, 3, 9, 1 (tlast on 1) -> max=9, idx=1, count=5, ovf=0, valid 1 cycle after the last handshake.
- SIGNED=1 packet of -4, -2, -7 -> max=-2 (0xFFFFFFFE), idx=1, count=3. The same packet with SIGNED=0 -> max=0xFFFFFFFE, idx=1.
- Back-to-back single-beat packets 7 then 3, m_axis_tready=1 -> results (7,0,1) then (3,0,1) on consecutive cycles, with s_axis_tready never low.
- Result pending with m_axis_tready=0 -> s_axis_tready=0 and outputs held. Raise m_axis_tready -> accept on that edge and s_axis_tready returns high.
- IDX_WIDTH=3, 10-beat packet with the max 100 at beat 8 -> count=7, idx=7, ovf=1.
- Reset asserted after 2 beats of a packet, then the packet 4, 6 -> only one result (6,1,2). With MIN_TRACK_EN defined, the same packet gives min=4, min_idx=0.

Source files
------------

// File: rtl/axis_max_finder.sv
// rtl/axis_max_finder.sv - AXI-Stream packet maximum finder with handshaked result
//
// Consumes TLAST-delimited packets and reports, once per packet, the maximum
// sample, the beat index of its first occurrence, the saturating beat count
// and an overflow flag. The result is a single registered entry.
//
// Optional feature macro: AXIS_MAX_FINDER_MIN_TRACK_EN
//   When defined, the packet minimum and its first index are tracked too and
//   reported on m_axis_min / m_axis_min_idx alongside the max result.
//
// Parameters:
//   DATA_WIDTH  sample width
//   IDX_WIDTH   width of the index and count fields
//   SIGNED      1 = two's-complement compare, 0 = unsigned compare
//
// Ports:
//   s_axis_aclk      clock, rising edge
//   s_axis_aresetn   asynchronous active-low reset
//   s_axis_tdata     input sample
//   s_axis_tvalid    input sample valid
//   s_axis_tlast     last beat of the packet
//   s_axis_tready    block can accept a beat
//   m_axis_tvalid    result valid
//   m_axis_tready    result accepted
//   m_axis_max       packet maximum
//   m_axis_idx       beat index of the first maximum (0-based, saturating)
//   m_axis_count     beats in the packet (saturating)
//   m_axis_ovf       packet exceeded 2^IDX_WIDTH-1 beats
//   m_axis_min       packet minimum (feature macro only)
//   m_axis_min_idx   beat index of the first minimum (feature macro only)

module axis_max_finder #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 16,
    parameter int SIGNED     = 0
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_max,
    output logic [IDX_WIDTH-1:0]  m_axis_idx,
    output logic [IDX_WIDTH-1:0]  m_axis_count,
    output logic                  m_axis_ovf
`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
    ,
    output logic [DATA_WIDTH-1:0] m_axis_min,
    output logic [IDX_WIDTH-1:0]  m_axis_min_idx
`endif
);

    localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] run_max, acc_max;
    logic [IDX_WIDTH-1:0]  run_idx, acc_idx;
    logic [IDX_WIDTH-1:0]  run_cnt, acc_cnt;
    logic                  run_ovf, acc_ovf;
    logic                  beat;
    logic                  gt;

`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
    logic [DATA_WIDTH-1:0] run_min, acc_min;
    logic [IDX_WIDTH-1:0]  run_min_idx, acc_min_idx;
    logic                  lt;
`endif

    // A pending result that is not being taken this cycle blocks the input;
    // taking it in the same cycle frees the slot for a new result.
    assign s_axis_tready = !(m_axis_tvalid && !m_axis_tready);
    assign beat          = s_axis_tvalid && s_axis_tready;

    always_comb begin
        gt = (SIGNED != 0) ? ($signed(s_axis_tdata) > $signed(run_max))
                           : (s_axis_tdata > run_max);
    end

`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
    always_comb begin
        lt = (SIGNED != 0) ? ($signed(s_axis_tdata) < $signed(run_min))
                           : (s_axis_tdata < run_min);
    end
`endif

    // Running values including the effect of the current beat. These feed
    // both the running registers and, on tlast, the result register.
    always_comb begin
        state_nxt = state;
        acc_max   = run_max;
        acc_idx   = run_idx;
        acc_cnt   = run_cnt;
        acc_ovf   = run_ovf;
`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
        acc_min     = run_min;
        acc_min_idx = run_min_idx;
`endif
        if (beat) begin
            if (state == ST_IDLE) begin
                acc_max = s_axis_tdata;
                acc_idx = '0;
                acc_cnt = IDX_ONE;
                acc_ovf = 1'b0;
`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
                acc_min     = s_axis_tdata;
                acc_min_idx = '0;
`endif
            end else begin
                // run_cnt is the number of beats already taken, i.e. the
                // index of this beat, already clamped at IDX_MAX.
                if (gt) begin
                    acc_max = s_axis_tdata;
                    acc_idx = run_cnt;
                end
`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
                if (lt) begin
                    acc_min     = s_axis_tdata;
                    acc_min_idx = run_cnt;
                end
`endif
                // A beat arriving with the counter already full means the
                // packet is longer than the count field can represent.
                if (run_cnt == IDX_MAX) begin
                    acc_ovf = 1'b1;
                end else begin
                    acc_cnt = run_cnt + IDX_ONE;
                end
            end
            state_nxt = s_axis_tlast ? ST_IDLE : ST_ACCUM;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            run_max       <= '0;
            run_idx       <= '0;
            run_cnt       <= '0;
            run_ovf       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_max    <= '0;
            m_axis_idx    <= '0;
            m_axis_count  <= '0;
            m_axis_ovf    <= 1'b0;
`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
            run_min        <= '0;
            run_min_idx    <= '0;
            m_axis_min     <= '0;
            m_axis_min_idx <= '0;
`endif
        end else begin
            if (beat) begin
                run_max <= acc_max;
                run_idx <= acc_idx;
                run_cnt <= acc_cnt;
                run_ovf <= acc_ovf;
`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
                run_min     <= acc_min;
                run_min_idx <= acc_min_idx;
`endif
            end
            if (beat && s_axis_tlast) begin
                m_axis_tvalid <= 1'b1;
                m_axis_max    <= acc_max;
                m_axis_idx    <= acc_idx;
                m_axis_count  <= acc_cnt;
                m_axis_ovf    <= acc_ovf;
`ifdef AXIS_MAX_FINDER_MIN_TRACK_EN
                m_axis_min     <= acc_min;
                m_axis_min_idx <= acc_min_idx;
`endif
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
